// File: rtl/bram_port_master_pkg.sv
// Shared helpers for the BRAM port master: count-width math and parameter checks.
package bram_port_master_pkg;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Width needed to hold the values 0..depth inclusive.
  function automatic int cnt_bitw(input int depth);
    int w;
    w = log2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit rd_latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/bram_port_master_if.sv
// BramPort bundle between the port master and the BRAM / data width converter.
interface bram_port_master_if #(
  parameter int ADDR_BITW = 32,
  parameter int DATA_BITW = 32
);
  logic                   Clk_C;
  logic                   Rst_R;
  logic                   En_S;
  logic [ADDR_BITW-1:0]   Addr_S;
  logic [DATA_BITW-1:0]   Wr_D;
  logic [DATA_BITW/8-1:0] WrEn_S;
  logic [DATA_BITW-1:0]   Rd_D;

  modport master (
    output Clk_C, Rst_R, En_S, Addr_S, Wr_D, WrEn_S,
    input  Rd_D
  );

  modport slave (
    input  Clk_C, Rst_R, En_S, Addr_S, Wr_D, WrEn_S,
    output Rd_D
  );
endinterface

// File: rtl/bram_port_master_rsp_fifo.sv
// Circular response buffer; the head is visible combinationally whenever non-empty.
module bram_port_master_rsp_fifo
  import bram_port_master_pkg::*;
#(
  parameter int DATA_BITW = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITW-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITW-1:0] head,
  output logic                 empty,
  output logic                 full
);

  localparam int PTR_BITW = (DEPTH > 1) ? log2(DEPTH) : 1;
  localparam int CNT_BITW = cnt_bitw(DEPTH);
  localparam logic [PTR_BITW-1:0] PTR_LAST = PTR_BITW'(DEPTH - 1);
  localparam logic [CNT_BITW-1:0] CNT_FULL = CNT_BITW'(DEPTH);

  logic [DATA_BITW-1:0] mem_q [DEPTH];
  logic [DATA_BITW-1:0] mem_d [DEPTH];
  logic [PTR_BITW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_BITW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_BITW-1:0]  cnt_q, cnt_d;

  function automatic logic [PTR_BITW-1:0] next_ptr(input logic [PTR_BITW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_BITW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_BITW'(1);
      2'b01:   cnt_d = cnt_q - CNT_BITW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_FULL);

endmodule

// File: rtl/bram_port_master.sv
// Valid/ready request front end for a BramPort: tracks the fixed read latency and
// returns read data in order, admitting reads only while a response slot is reserved.
module bram_port_master
  import bram_port_master_pkg::*;
#(
  parameter int ADDR_BITW      = 32,
  parameter int DATA_BITW      = 32,
  parameter int RD_LATENCY     = 1,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                   Clk_C,
  input  logic                   Rst_RBI,
  input  logic                   Req_Valid_S,
  output logic                   Req_Ready_S,
  input  logic [ADDR_BITW-1:0]   Req_Addr_S,
  input  logic [DATA_BITW/8-1:0] Req_WrEn_S,
  input  logic [DATA_BITW-1:0]   Req_Wr_D,
  output logic                   Rsp_Valid_S,
  input  logic                   Rsp_Ready_S,
  output logic [DATA_BITW-1:0]   Rsp_Rd_D,
  bram_port_master_if.master     ToBram_PM
);

  localparam int CNT_BITW = cnt_bitw(RSP_FIFO_DEPTH);
  localparam logic [CNT_BITW-1:0] CNT_MAX = CNT_BITW'(RSP_FIFO_DEPTH);
  localparam bit PARAMS_OK = ((DATA_BITW % 8) == 0) && rd_latency_ok(RD_LATENCY)
                             && (RSP_FIFO_DEPTH >= RD_LATENCY + 1);

  logic [CNT_BITW-1:0]   cnt_q, cnt_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;

  logic                 is_rd;
  logic                 accept;
  logic                 rd_acc;
  logic                 rd_vld;
  logic                 rsp_hs;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [DATA_BITW-1:0] fifo_head;
  logic                 fifo_empty;
  logic                 fifo_full;

  // Credit counter covers reads in flight plus buffered responses, so the FIFO
  // always has room for every returning beat.
  always_comb begin
    is_rd       = (Req_WrEn_S == '0);
    Req_Ready_S = Rst_RBI && (!is_rd || (cnt_q < CNT_MAX));
    accept      = Req_Valid_S && Req_Ready_S;
    rd_acc      = accept && is_rd;

    rd_vld      = vld_q[RD_LATENCY-1];
    Rsp_Valid_S = !fifo_empty || rd_vld;
    if (!fifo_empty) begin
      Rsp_Rd_D = fifo_head;
    end else if (rd_vld) begin
      Rsp_Rd_D = ToBram_PM.Rd_D;
    end else begin
      Rsp_Rd_D = '0;
    end
    rsp_hs    = Rsp_Valid_S && Rsp_Ready_S;
    fifo_pop  = rsp_hs && !fifo_empty;
    // Returning data bypasses the buffer only when nothing older waits and it is taken now.
    fifo_push = rd_vld && !(fifo_empty && Rsp_Ready_S);

    vld_d = RD_LATENCY'({vld_q, rd_acc});

    unique case ({rd_acc, rsp_hs})
      2'b10:   cnt_d = cnt_q + CNT_BITW'(1);
      2'b01:   cnt_d = cnt_q - CNT_BITW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clk_C or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  assign ToBram_PM.Clk_C  = Clk_C;
  assign ToBram_PM.Rst_R  = ~Rst_RBI;
  assign ToBram_PM.En_S   = accept;
  assign ToBram_PM.Addr_S = Req_Addr_S;
  assign ToBram_PM.WrEn_S = accept ? Req_WrEn_S : '0;
  assign ToBram_PM.Wr_D   = Req_Wr_D;

  bram_port_master_rsp_fifo #(
    .DATA_BITW (DATA_BITW),
    .DEPTH     (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (Clk_C),
    .rst_n     (Rst_RBI),
    .push      (fifo_push),
    .push_data (ToBram_PM.Rd_D),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  ap_params: assert property (@(posedge Clk_C)
    PARAMS_OK && ($bits(ToBram_PM.Addr_S) == ADDR_BITW) && ($bits(ToBram_PM.Rd_D) == DATA_BITW));

  ap_no_overflow: assert property (@(posedge Clk_C) disable iff (!Rst_RBI)
    !(fifo_push && fifo_full));

endmodule
